// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad scanner:
//   - scan_state_t : scanner FSM states
//   - KEY_MAP      : 16-entry hex code table indexed by {row, col}
//   - COL_ONECOLD  : active-low column drive patterns indexed by column
//   - lowest_low_row() : priority pick of the lowest-index active row
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } scan_state_t;

  // Physical layout, row-major, column index left to right:
  //   row0: 1 2 3 A / row1: 4 5 6 B / row2: 7 8 9 C / row3: 0 F E D
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  localparam logic [3:0] COL_ONECOLD [4] = '{
    4'b1110, 4'b1101, 4'b1011, 4'b0111
  };

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[{row, col}];
  endfunction

  // When several rows are low together the lowest index wins.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
    if (!rows_n[0])      return 2'd0;
    else if (!rows_n[1]) return 2'd1;
    else if (!rows_n[2]) return 2'd2;
    else                 return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync
// Two-flop synchronizer for the asynchronous keypad row lines.
// Reset value is all ones (rows idle high through their pull-ups).
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   d     - raw row inputs (asynchronous to clk)
//   q     - synchronized rows, two clocks of latency
module keypad_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 matrix keypad one column per slot, debounces presses and
// releases, and presents the accepted key as a hex code with a
// valid/ack handshake.
// Parameters:
//   SCAN_DIV     - clocks per column slot (>= 4)
//   DEBOUNCE_CNT - consecutive agreeing samples for press and release (1..15)
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   col_n[3:0]  - column drive, active low, one-cold
//   row_n[3:0]  - row sense, pulled up, active low, asynchronous
//   key_code    - hex value of the last accepted key
//   key_valid   - key_code holds a key not yet acknowledged
//   key_ack     - consumer takes key_code
//   key_held    - accepted key is still pressed
//   key_overrun - one-cycle pulse when a key is accepted while one is pending
module keypad_scanner #(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       key_overrun
);

  import keypad_pkg::*;

  localparam int              SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB_LAST  = 4'(DEBOUNCE_CNT - 1);

  logic [3:0]        row_sync;
  logic [SLOT_W-1:0] slot_cnt;
  logic              sample;
  scan_state_t       state, state_nxt;
  logic [1:0]        col_idx, col_idx_nxt;
  logic [1:0]        cand_row, cand_row_nxt;
  logic [3:0]        deb_cnt, deb_cnt_nxt;
  logic [3:0]        cnt_inc;
  logic              cand_low;
  logic              accept;
  logic              ack_ok;

  keypad_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_n),
    .q     (row_sync)
  );

  // Slot timer: free-running, the last cycle of each slot is the sample point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  assign sample = (slot_cnt == SLOT_LAST);

  // FSM state, column pointer, candidate row and debounce counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_SCAN;
      col_idx  <= 2'd0;
      cand_row <= 2'd0;
      deb_cnt  <= 4'd0;
    end else begin
      state    <= state_nxt;
      col_idx  <= col_idx_nxt;
      cand_row <= cand_row_nxt;
      deb_cnt  <= deb_cnt_nxt;
    end
  end

  // Next-state logic. Decisions are only taken at sample points. While a
  // candidate is being tracked the column stays put, so only the candidate
  // row matters and any other key is ignored. The first sample that starts
  // a debounce or release run counts as sample zero; the run completes when
  // the incremented count reaches DEBOUNCE_CNT-1.
  always_comb begin
    state_nxt    = state;
    col_idx_nxt  = col_idx;
    cand_row_nxt = cand_row;
    deb_cnt_nxt  = deb_cnt;
    accept       = 1'b0;
    cand_low     = ~row_sync[cand_row];
    cnt_inc      = deb_cnt + 4'd1;

    if (sample) begin
      case (state)
        ST_SCAN: begin
          if (row_sync != 4'hF) begin
            cand_row_nxt = lowest_low_row(row_sync);
            deb_cnt_nxt  = 4'd0;
            state_nxt    = ST_DEBOUNCE;
          end else begin
            col_idx_nxt = col_idx + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (cand_low) begin
            deb_cnt_nxt = cnt_inc;
            if (cnt_inc >= DEB_LAST) begin
              accept    = 1'b1;
              state_nxt = ST_HELD;
            end
          end else begin
            state_nxt   = ST_SCAN;
            col_idx_nxt = col_idx + 2'd1;
          end
        end
        ST_HELD: begin
          if (!cand_low) begin
            deb_cnt_nxt = 4'd0;
            state_nxt   = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!cand_low) begin
            deb_cnt_nxt = cnt_inc;
            if (cnt_inc >= DEB_LAST) begin
              state_nxt   = ST_SCAN;
              col_idx_nxt = col_idx + 2'd1;
            end
          end else begin
            state_nxt = ST_HELD;
          end
        end
        default: state_nxt = ST_SCAN;
      endcase
    end
  end

  assign ack_ok = key_ack & key_valid;

  // Output handshake. A new key replaces the pending one only if the
  // pending one is being acknowledged in the same cycle; otherwise the new
  // key is dropped and reported as an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code    <= 4'h0;
      key_valid   <= 1'b0;
      key_overrun <= 1'b0;
    end else begin
      key_overrun <= 1'b0;
      if (accept) begin
        if (!key_valid || ack_ok) begin
          key_code  <= key_lookup(cand_row, col_idx);
          key_valid <= 1'b1;
        end else begin
          key_overrun <= 1'b1;
        end
      end else if (ack_ok) begin
        key_valid <= 1'b0;
      end
    end
  end

  assign col_n    = COL_ONECOLD[col_idx];
  assign key_held = (state == ST_HELD) || (state == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Drives keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3) through a model of a
// physical key matrix and compares every output, every cycle, against a
// sample-level behavioural model. Directed scenarios add hand-computed
// literal expectations.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 3;

  localparam int MD_IDLE  = 0;
  localparam int MD_PRESS = 1;
  localparam int MD_HOLD  = 2;
  localparam int MD_REL   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       key_held;
  logic       key_overrun;

  // Pressed switches, bit index = row*4 + col.
  logic [15:0] pressed = '0;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int ov_seen   = 0;
  bit check_en  = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV     (SD),
    .DEBOUNCE_CNT (DC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .col_n       (col_n),
    .row_n       (row_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ack     (key_ack),
    .key_held    (key_held),
    .key_overrun (key_overrun)
  );

  // Switch matrix: a row reads low when a pressed switch joins it to a
  // column that is currently driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  // Behavioural model, expressed in samples: each key event needs DC
  // consecutive agreeing samples, the row view is two clocks old.
  int         key_map [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
  int         m_tick, m_col, m_mode, m_agree, m_row;
  logic [3:0] m_h1, m_h2, m_seen, m_code;
  bit         m_valid, m_ovr, m_acc, m_ackok;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tick = 0; m_col = 0; m_mode = MD_IDLE; m_agree = 0; m_row = 0;
      m_h1 = 4'hF; m_h2 = 4'hF; m_code = 4'h0;
      m_valid = 1'b0; m_ovr = 1'b0;
    end else begin
      m_seen  = m_h2;
      m_h2    = m_h1;
      m_h1    = row_n;
      m_ackok = key_ack && m_valid;
      m_acc   = 1'b0;
      m_ovr   = 1'b0;
      if (m_tick == SD - 1) begin
        case (m_mode)
          MD_IDLE: begin
            if (m_seen != 4'hF) begin
              m_row = 3;
              for (int r = 3; r >= 0; r--) if (!m_seen[r]) m_row = r;
              m_agree = 1;
              m_mode  = MD_PRESS;
            end else begin
              m_col = (m_col + 1) % 4;
            end
          end
          MD_PRESS: begin
            if (!m_seen[m_row]) begin
              m_agree++;
              if (m_agree >= DC) begin m_acc = 1'b1; m_mode = MD_HOLD; end
            end else begin
              m_mode = MD_IDLE;
              m_col  = (m_col + 1) % 4;
            end
          end
          MD_HOLD: begin
            if (m_seen[m_row]) begin m_agree = 1; m_mode = MD_REL; end
          end
          default: begin
            if (m_seen[m_row]) begin
              m_agree++;
              if (m_agree >= DC) begin m_mode = MD_IDLE; m_col = (m_col + 1) % 4; end
            end else begin
              m_mode = MD_HOLD;
            end
          end
        endcase
      end
      m_tick = (m_tick + 1) % SD;
      if (m_acc) begin
        if (!m_valid || m_ackok) begin
          m_code  = 4'(key_map[m_row*4+m_col]);
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_ackok) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Cycle-by-cycle compare against the model, away from the active edge.
  logic [3:0] e_col;
  always @(negedge clk) begin
    if (check_en) begin
      e_col = 4'hF ^ (4'h1 << m_col);
      checkOutput("model col_n", col_n, e_col);
      checkOutput("model key_code", key_code, m_code);
      checkOutput("model key_valid", {3'b0, key_valid}, {3'b0, m_valid});
      checkOutput("model key_held", {3'b0, key_held},
                  {3'b0, (m_mode == MD_HOLD) || (m_mode == MD_REL)});
      checkOutput("model key_overrun", {3'b0, key_overrun}, {3'b0, m_ovr});
    end
  end

  always @(negedge clk) if (key_overrun === 1'b1) ov_seen++;

  task automatic applyStimulus(input logic [15:0] mask);
    @(negedge clk);
    pressed = mask;
  endtask

  // which: 0 = key_valid, 1 = key_held
  task automatic waitFor(input string name, input int which, input logic level, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = (which == 0) ? (key_valid === level) : (key_held === level);
    end
    check_cnt++;
    if (hit) pass_cnt++;
    else $display("[TB] FAIL %s: no level %0b within %0d cycles", name, level, budget);
  endtask

  // Returns at the first negedge after col_n switches to column 0.
  task automatic waitCol0(input string name);
    logic [3:0] prev = col_n;
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      hit  = (col_n == 4'b1110) && (prev != 4'b1110);
      prev = col_n;
    end
    check_cnt++;
    if (hit) pass_cnt++;
    else $display("[TB] FAIL %s: column 0 never started", name);
  endtask

  task automatic ackKey();
    @(negedge clk);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  logic [3:0] col_seq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    $display("[TB] keypad_scanner bench start");
    #2 rst_n = 1'b0;
    check_en = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset col_n", col_n, 4'b1110);
    checkOutput("reset key_valid", {3'b0, key_valid}, 4'h0);
    checkOutput("reset key_code", key_code, 4'h0);
    checkOutput("reset key_held", {3'b0, key_held}, 4'h0);
    #2 rst_n = 1'b1;

    // Idle scan: one column step every SD clocks.
    for (int i = 0; i < 4; i++) begin
      repeat (SD) @(posedge clk);
      @(negedge clk);
      checkOutput("idle col_n step", col_n, col_seq[i]);
      checkOutput("idle key_valid", {3'b0, key_valid}, 4'h0);
    end

    // Key 6 (row1, col2), then acknowledge.
    applyStimulus(16'h0040);
    waitFor("key6 valid", 0, 1'b1, 100);
    checkOutput("key6 code", key_code, 4'h6);
    checkOutput("key6 held", {3'b0, key_held}, 4'h1);
    ackKey();
    checkOutput("key6 ack clears valid", {3'b0, key_valid}, 4'h0);
    applyStimulus(16'h0000);
    waitFor("key6 release", 1, 1'b0, 100);

    // Single-sample bounce on key 1 (row0, col0).
    waitCol0("bounce col0");
    pressed = 16'h0001;
    repeat (SD) @(negedge clk);
    pressed = 16'h0000;
    repeat (40) @(negedge clk);
    checkOutput("bounce no valid", {3'b0, key_valid}, 4'h0);
    checkOutput("bounce no held", {3'b0, key_held}, 4'h0);

    // Key 5 left pending, then key D -> one overrun, code stays 5.
    ov_seen = 0;
    applyStimulus(16'h0020);
    waitFor("key5 valid", 0, 1'b1, 100);
    checkOutput("key5 code", key_code, 4'h5);
    applyStimulus(16'h0000);
    waitFor("key5 release", 1, 1'b0, 100);
    applyStimulus(16'h8000);
    waitFor("keyD held", 1, 1'b1, 100);
    repeat (4) @(negedge clk);
    checkOutput("overrun pulse count", 4'(ov_seen), 4'd1);
    checkOutput("overrun code kept", key_code, 4'h5);
    checkOutput("overrun valid kept", {3'b0, key_valid}, 4'h1);
    applyStimulus(16'h0000);
    waitFor("keyD release", 1, 1'b0, 100);
    ackKey();

    // Keys 2 and F on column 1 together: lowest row wins.
    applyStimulus(16'h2002);
    waitFor("multi valid", 0, 1'b1, 100);
    checkOutput("multi code", key_code, 4'h2);
    applyStimulus(16'h0000);
    waitFor("multi release", 1, 1'b0, 100);

    // Reset during debounce while key 2 is still pending.
    ov_seen = 0;
    waitCol0("reset col0");
    pressed = 16'h0001;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid reset col_n", col_n, 4'b1110);
    checkOutput("mid reset key_valid", {3'b0, key_valid}, 4'h0);
    checkOutput("mid reset key_code", key_code, 4'h0);
    checkOutput("mid reset key_held", {3'b0, key_held}, 4'h0);
    pressed = 16'h0000;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (60) @(negedge clk);
    checkOutput("post reset no valid", {3'b0, key_valid}, 4'h0);
    checkOutput("post reset no overrun", 4'(ov_seen), 4'd0);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clocks per column slot (1 ms at 100 MHz); legal range >= 4.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4, meaning consecutive agreeing samples required for press and for release; legal range 1..15.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, 100 MHz onboard clock) and rst_n (input, 1, asynchronous active-low reset).
REQ-004 SHALL have port col_n, output, 4 bits: keypad column drive, active low, one-cold.
REQ-005 SHALL have port row_n, input, 4 bits: keypad row sense, pulled up, active low, asynchronous to clk.
REQ-006 SHALL have port key_code, output, 4 bits: hex value of the last accepted key.
REQ-007 SHALL have port key_valid, output, 1 bit: key_code holds an unconsumed key.
REQ-008 SHALL have port key_ack, input, 1 bit: consumer accepts key_code.
REQ-009 SHALL have port key_held, output, 1 bit: the accepted key is still physically pressed.
REQ-010 SHALL have port key_overrun, output, 1 bit: one-cycle pulse when a key is lost.

Function
REQ-011 SHALL pass row_n through a 2-flop synchronizer before any use; synchronizer latency is 2 clocks.
REQ-012 SHALL drive exactly one col_n bit low at all times after reset, in the order col0->col1->col2->col3->col0.
REQ-013 SHALL use a slot counter of width clog2(SCAN_DIV) that wraps at SCAN_DIV-1; the sample point is the slot's last cycle (count == SCAN_DIV-1).
REQ-014 SHALL implement states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-015 In SCAN, SHALL advance the column at each slot end; on a sample with any synchronized row low, it SHALL latch the candidate (current column, lowest-index low row), hold the column, clear the debounce count and enter DEBOUNCE.
REQ-016 In DEBOUNCE, SHALL increment the count on each sample where the candidate row is low; when count reaches DEBOUNCE_CNT-1 it SHALL accept the key and enter HELD; if the row is high at any sample it SHALL return to SCAN and advance the column.
REQ-017 SHALL map the key as row0: 1 2 3 A, row1: 4 5 6 B, row2: 7 8 9 C, row3: 0 F E D (column index left to right).
REQ-018 On acceptance with key_valid low, SHALL load key_code and assert key_valid on the next clock.
REQ-019 On acceptance with key_valid high, SHALL keep key_code unchanged and pulse key_overrun for one clock.
REQ-020 SHALL clear key_valid on the clock after key_ack is sampled high while key_valid is high; key_ack while key_valid is low SHALL be ignored.
REQ-021 If acceptance and a valid ack occur in the same cycle, SHALL load the new code and keep key_valid high, with no overrun.
REQ-022 In HELD, SHALL keep the column fixed and assert key_held; the first sample with the candidate row high SHALL enter RELEASE with the count cleared.
REQ-023 In RELEASE, SHALL increment the count on each high sample and return to HELD on a low sample; at DEBOUNCE_CNT-1 it SHALL enter SCAN, deassert key_held and advance the column.
REQ-024 SHALL ignore other keys pressed while in DEBOUNCE, HELD or RELEASE.

Reset
REQ-025 While rst_n is low, SHALL force state=SCAN, col_n=4'b1110, slot and debounce counters=0, key_code=4'h0, key_valid=0, key_held=0, key_overrun=0 and the synchronizer flops to 1.
REQ-026 Reset asserted mid-debounce or while key_valid is high SHALL discard the pending key without any overrun pulse.

Structure
REQ-027 SHALL place the state enum, the 16-entry key map table and the one-cold column constants in shared package keypad_pkg.
REQ-028 SHALL instantiate one sub-module, keypad_sync (4-bit 2-flop synchronizer with asynchronous active-low reset, reset value 1).

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-029 Reset release, no key -> col_n cycles 1110,1101,1011,0111 every 4 clocks; key_valid=0.
REQ-030 Hold row1 low during col2 -> key_code=4'h6, key_valid=1 after 3 stable samples, key_held=1; key_ack -> key_valid=0 next clock.
REQ-031 Bounce row0/col0 low for 1 sample then high -> return to SCAN, no key_valid.
REQ-032 Accept 4'h5 with no ack, release, then press 4'hD -> key_overrun pulses once; key_code stays 4'h5.
REQ-033 Press row0 and row3 on col1 simultaneously -> key_code=4'h2.
REQ-034 Assert rst_n low in DEBOUNCE -> all outputs at reset values; col_n=1110; no key emitted after release.
